rasterizer_depth_writeback: RTL and testbench
=============================================

Name: rasterizer_depth_writeback

Overview:
- Downstream of the rasterizer fetch stage.
- Consumes fragments that carry the pixel address, the old depth read from SDRAM, the new depth and the colour.
- Performs the depth test and, on pass, writes the new depth word and then the colour word to SDRAM over a 32-bit Avalon-MM write master.
- Buffers fragments in a small FIFO because the fetch stage has no backpressure input.

Parameters:
- FIFO_DEPTH, 4: fragment buffer entries; power of two, ≥2.
- COLOR_OFFSET, 26'h0200000: byte offset added mod 2^26 to the depth address to form the colour address.
- LESS_EQUAL, 0: 0 means pass if new<old; 1 means pass if new<=old. Compare is unsigned 32-bit.
- CNT_W, 16: statistics counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  fragment present this cycle (fetch stage output_valid)
- in_addr  in  26  depth-buffer byte address
- in_old_depth  in  32  depth currently in buffer
- in_new_depth  in  32  fragment depth
- in_color  in  24  fragment RGB
- in_almost_full  out  1  FIFO count ≥ FIFO_DEPTH-1; upstream throttling hint
- overflow  out  1  sticky: in_valid seen while FIFO full
- master_address  out  26  Avalon byte address
- master_write  out  1  Avalon write strobe
- master_byteenable  out  4  always 4'b1111 when writing
- master_writedata  out  32  write data
- master_waitrequest  in  1  Avalon stall
- clear_stats  in  1  synchronous clear of counters and overflow
- pass_count  out  CNT_W  fragments that passed; saturating
- fail_count  out  CNT_W  fragments that failed; saturating
- idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (async, reset=1):
  - FIFO empty, FSM in IDLE.
  - master_write=0, master_address=0, master_writedata=0, master_byteenable=0.
  - overflow=0, pass_count=0, fail_count=0, in_almost_full=0, idle=1.
  - Reset mid-transaction abandons the write immediately; no completion is owed.
- Input:
  - in_valid with FIFO not full: enqueue {addr, old, new, color} at the clock edge.
  - in_valid with FIFO full: fragment dropped; overflow<=1, sticky until clear_stats or reset.
  - in_almost_full is registered from the FIFO count.
- FSM states: IDLE, WR_DEPTH, WR_COLOR, POP.
  - IDLE, FIFO non-empty: evaluate head.
    - Pass: go to WR_DEPTH; drive master_write=1, master_address=addr, master_writedata=new_depth; pass_count++.
    - Fail: go to POP; fail_count++; no bus activity.
  - WR_DEPTH: hold all master_* stable while master_waitrequest=1.
    - On the first cycle with waitrequest=0, the write is accepted.
    - Next cycle: WR_COLOR, with master_address=addr+COLOR_OFFSET (26-bit wrap) and master_writedata={8'h00,color}.
  - WR_COLOR: same hold rule; on accept go to POP with master_write=0.
  - POP: dequeue head, return to IDLE.
- Latency and throughput:
  - Fragment enqueued at edge N: head of an empty FIFO at N+1; master_write rises at edge N+2 at the earliest.
  - Passing fragment with no waitrequest: 4 cycles (IDLE, WR_DEPTH, WR_COLOR, POP).
  - Failing fragment: 2 cycles.
- master_byteenable is 4'b1111 whenever master_write=1, else 0. master_write is never asserted in IDLE or POP.
- Simultaneous enqueue and dequeue in POP with the FIFO full: the enqueue is accepted and the count is unchanged; no overflow.
- Counters: saturate at all-ones. clear_stats has priority over an increment in the same cycle.
- Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- idle = (count==0) && state==IDLE.

Test Plan:
- Pass, no stall: addr=26'h000100, old=32'h00000080, new=32'h00000040, color=24'hFF8800 -> write 26'h000100/32'h00000040, then 26'h200100/32'h00FF8800; pass_count=1; idle after 4 cycles.
- Fail and LESS_EQUAL: with LESS_EQUAL=0, old=new=32'h10 -> no master_write, fail_count=1. Same fragment with LESS_EQUAL=1 -> two writes.
- Waitrequest hold: waitrequest high for 3 cycles during WR_DEPTH -> address and data unchanged across all 4 cycles; colour write follows only after accept.
- Overflow: hold waitrequest=1, then 6 back-to-back in_valid with FIFO_DEPTH=4 -> in_almost_full=1 after the 3rd enqueue, overflow=1; exactly 4 fragments eventually written, in order.
- Wrap and saturation: addr=26'h3FFFFF0 -> colour address 26'h01FFFF0. Force pass_count to 16'hFFFF then send a pass -> stays 16'hFFFF. clear_stats -> counts 0 and overflow 0.
- Reset mid-write: assert reset during WR_COLOR -> master_write=0 immediately (asynchronous), FIFO empty, idle=1.

Source files
------------

// File: rtl/rasterizer_depth_writeback.sv
// rasterizer_depth_writeback
//   Depth-test and write-back stage that sits behind the rasterizer fetch
//   stage. Incoming fragments are buffered in a small FIFO, because fetch
//   cannot be stalled. Each head fragment is depth-tested. A passing fragment
//   is written to SDRAM as two 32-bit Avalon-MM writes: the depth word first,
//   then the colour word.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   in_valid/in_*       fragment from fetch: address, old/new depth, colour
//   in_almost_full      registered: FIFO holds >= FIFO_DEPTH-1 entries
//   overflow            sticky: a fragment arrived while the FIFO was full
//   master_*            Avalon-MM write master (byte address, 32-bit data)
//   clear_stats         synchronous clear of the counters and overflow
//   pass_count/fail_count  saturating depth-test statistics
//   idle                FIFO empty and FSM in IDLE (registered)
module rasterizer_depth_writeback #(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [25:0] COLOR_OFFSET = 26'h0200000,
    parameter bit          LESS_EQUAL   = 1'b0,
    parameter int          CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [25:0]      in_addr,
    input  logic [31:0]      in_old_depth,
    input  logic [31:0]      in_new_depth,
    input  logic [23:0]      in_color,
    output logic             in_almost_full,
    output logic             overflow,
    output logic [25:0]      master_address,
    output logic             master_write,
    output logic [3:0]       master_byteenable,
    output logic [31:0]      master_writedata,
    input  logic             master_waitrequest,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [25:0] addr;
        logic [31:0] old_d;
        logic [31:0] new_d;
        logic [23:0] color;
    } frag_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_DEPTH = 2'd1,
        ST_WR_COLOR = 2'd2,
        ST_POP      = 2'd3
    } state_t;

    frag_t          mem_q [FIFO_DEPTH];
    frag_t          frag_in_s;
    frag_t          head_q;
    logic           head_vld_q;
    logic           head_vld_d;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  rd_ptr_d;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           full_s;
    logic           pop_s;
    logic           push_s;
    logic           drop_s;
    logic           pass_s;
    logic           pass_evt_s;
    logic           fail_evt_s;
    logic           going_idle_s;

    state_t         state_q;
    logic [25:0]    addr_q;
    logic           write_q;
    logic [3:0]     be_q;
    logic [31:0]    data_q;
    logic [CNT_W-1:0] pass_cnt_q;
    logic [CNT_W-1:0] fail_cnt_q;
    logic           overflow_q;
    logic           almost_full_q;
    logic           idle_q;

    assign frag_in_s = {in_addr, in_old_depth, in_new_depth, in_color};
    assign full_s    = (count_q == CW'(FIFO_DEPTH));
    assign pop_s     = (state_q == ST_POP);
    // A full FIFO still accepts a fragment in the cycle its head is removed.
    assign push_s    = in_valid && (!full_s || pop_s);
    assign drop_s    = in_valid && full_s && !pop_s;

    // FIFO occupancy and read-pointer next state.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // The head register only sees entries written before this edge, so a
        // fragment reaches the head one cycle after it is enqueued.
        if (pop_s) begin
            head_vld_d = (count_q > CW'(1));
        end else begin
            head_vld_d = (count_q != CW'(0));
        end
    end

    // Depth test on the registered head fragment, plus the resulting events.
    always_comb begin
        if (LESS_EQUAL) begin
            pass_s = (head_q.new_d <= head_q.old_d);
        end else begin
            pass_s = (head_q.new_d < head_q.old_d);
        end
        pass_evt_s   = (state_q == ST_IDLE) && head_vld_q && pass_s;
        fail_evt_s   = (state_q == ST_IDLE) && head_vld_q && !pass_s;
        going_idle_s = (state_q == ST_POP) || ((state_q == ST_IDLE) && !head_vld_q);
    end

    // Fragment storage; data only, the pointers and count qualify it.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= frag_in_s;
        end
    end

    // FIFO pointers, count, head register and the almost-full hint.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            head_q        <= '0;
            head_vld_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            head_q        <= mem_q[rd_ptr_d];
            head_vld_q    <= head_vld_d;
            almost_full_q <= (count_d >= CW'(FIFO_DEPTH - 1));
        end
    end

    // Write-back FSM with registered Avalon outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 26'd0;
            write_q <= 1'b0;
            be_q    <= 4'b0000;
            data_q  <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (head_vld_q) begin
                        if (pass_s) begin
                            state_q <= ST_WR_DEPTH;
                            write_q <= 1'b1;
                            be_q    <= 4'b1111;
                            addr_q  <= head_q.addr;
                            data_q  <= head_q.new_d;
                        end else begin
                            state_q <= ST_POP;
                        end
                    end
                end
                ST_WR_DEPTH: begin
                    if (!master_waitrequest) begin
                        state_q <= ST_WR_COLOR;
                        addr_q  <= head_q.addr + COLOR_OFFSET;
                        data_q  <= {8'h00, head_q.color};
                    end
                end
                ST_WR_COLOR: begin
                    if (!master_waitrequest) begin
                        state_q <= ST_POP;
                        write_q <= 1'b0;
                        be_q    <= 4'b0000;
                    end
                end
                ST_POP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    write_q <= 1'b0;
                    be_q    <= 4'b0000;
                end
            endcase
        end
    end

    // Saturating statistics, sticky overflow and the registered idle flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            overflow_q <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            if (clear_stats) begin
                pass_cnt_q <= '0;
                fail_cnt_q <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (pass_evt_s && (pass_cnt_q != {CNT_W{1'b1}})) begin
                    pass_cnt_q <= pass_cnt_q + CNT_W'(1);
                end
                if (fail_evt_s && (fail_cnt_q != {CNT_W{1'b1}})) begin
                    fail_cnt_q <= fail_cnt_q + CNT_W'(1);
                end
                if (drop_s) begin
                    overflow_q <= 1'b1;
                end
            end
            idle_q <= going_idle_s && (count_d == CW'(0));
        end
    end

    assign master_address    = addr_q;
    assign master_write      = write_q;
    assign master_byteenable = be_q;
    assign master_writedata  = data_q;
    assign pass_count        = pass_cnt_q;
    assign fail_count        = fail_cnt_q;
    assign overflow          = overflow_q;
    assign in_almost_full    = almost_full_q;
    assign idle              = idle_q;

endmodule

// File: tb/tb_rasterizer_depth_writeback.sv
// Testbench for rasterizer_depth_writeback. Two instances share all inputs:
// "dut" uses the defaults (strict less-than, 16-bit counters) and is fully
// checked against a queue-based model of the expected Avalon writes; "le"
// uses LESS_EQUAL=1 with 4-bit counters to exercise the inclusive compare and
// counter saturation cheaply.
module tb_rasterizer_depth_writeback;

    localparam logic [25:0] COFF = 26'h0200000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [25:0] in_addr = 26'd0;
    logic [31:0] in_old_depth = 32'd0;
    logic [31:0] in_new_depth = 32'd0;
    logic [23:0] in_color = 24'd0;
    logic        clear_stats = 1'b0;
    int          wait_mode = 0;
    logic        rnd_wait = 1'b0;
    logic        waitrequest;

    logic        af, ovf, m_write, idle;
    logic [25:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_data;
    logic [15:0] pass_cnt, fail_cnt;

    logic        le_af, le_ovf, le_write, le_idle;
    logic [25:0] le_addr;
    logic [3:0]  le_be;
    logic [31:0] le_data;
    logic [3:0]  le_pass, le_fail;

    int errors = 0;
    int checks = 0;
    int exp_pass = 0;
    int exp_fail = 0;
    int exp_le_pass = 0;
    int le_writes = 0;
    logic [25:0] last_wr_addr = 26'd0;

    typedef struct packed {
        logic [25:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    assign waitrequest = (wait_mode == 2) ? rnd_wait : (wait_mode == 1);

    always #5 clock = ~clock;

    always @(posedge clock) rnd_wait <= ($urandom_range(0, 3) == 0);

    rasterizer_depth_writeback dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_addr(in_addr),
        .in_old_depth(in_old_depth), .in_new_depth(in_new_depth), .in_color(in_color),
        .in_almost_full(af), .overflow(ovf), .master_address(m_addr),
        .master_write(m_write), .master_byteenable(m_be), .master_writedata(m_data),
        .master_waitrequest(waitrequest), .clear_stats(clear_stats),
        .pass_count(pass_cnt), .fail_count(fail_cnt), .idle(idle)
    );

    rasterizer_depth_writeback #(.LESS_EQUAL(1'b1), .CNT_W(4)) le (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_addr(in_addr),
        .in_old_depth(in_old_depth), .in_new_depth(in_new_depth), .in_color(in_color),
        .in_almost_full(le_af), .overflow(le_ovf), .master_address(le_addr),
        .master_write(le_write), .master_byteenable(le_be), .master_writedata(le_data),
        .master_waitrequest(waitrequest), .clear_stats(clear_stats),
        .pass_count(le_pass), .fail_count(le_fail), .idle(le_idle)
    );

    // Bus monitor, sampled on the falling edge: byte enables, stall hold and
    // in-order comparison of every accepted write against the model queue.
    logic        prev_stall = 1'b0;
    logic [25:0] prev_addr = 26'd0;
    logic [31:0] prev_data = 32'd0;
    always @(negedge clock) begin
        wr_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (m_be !== (m_write ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL byteenable: got=%h write=%b", m_be, m_write);
            end
            if (prev_stall) begin
                checks++;
                if (m_write !== 1'b1 || m_addr !== prev_addr || m_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got %b/%h/%h required 1/%h/%h",
                             m_write, m_addr, m_data, prev_addr, prev_data);
                end
            end
            if (m_write === 1'b1 && waitrequest === 1'b0) begin
                checks++;
                last_wr_addr = m_addr;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %h/%h with nothing pending", m_addr, m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_addr !== e.a || m_data !== e.d) begin
                        errors++;
                        $display("FAIL write_seq: got %h/%h required %h/%h", m_addr, m_data, e.a, e.d);
                    end
                end
            end
            prev_stall = m_write && waitrequest;
            prev_addr  = m_addr;
            prev_data  = m_data;
            if (le_write === 1'b1 && waitrequest === 1'b0) le_writes++;
        end
    end

    // Reference model: the expected writes and statistics for one accepted fragment.
    task automatic model_frag(input logic [25:0] fa, input logic [31:0] fo,
                              input logic [31:0] fn, input logic [23:0] fc);
        logic [25:0] ca;
        ca = fa + COFF;
        if (fn < fo) begin
            exp_q.push_back(wr_t'{fa, fn});
            exp_q.push_back(wr_t'{ca, {8'h00, fc}});
            exp_pass++;
        end else begin
            exp_fail++;
        end
        if (fn <= fo && exp_le_pass < 15) exp_le_pass++;
    endtask

    // Present a fragment for exactly one clock edge.
    task automatic drive_frag(input logic [25:0] fa, input logic [31:0] fo,
                              input logic [31:0] fn, input logic [23:0] fc, input bit accepted);
        in_valid = 1'b1;
        in_addr = fa; in_old_depth = fo; in_new_depth = fn; in_color = fc;
        if (accepted) model_frag(fa, fo, fn, fc);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Send a fragment once the FIFO has room (in_almost_full low).
    task automatic send(input logic [25:0] fa, input logic [31:0] fo,
                        input logic [31:0] fn, input logic [23:0] fc);
        int guard = 0;
        while (af !== 1'b0 && guard < 300) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 300) begin
            checks++; errors++;
            $display("FAIL send_throttle: almost_full stuck at %b", af);
        end
        drive_frag(fa, fo, fn, fc, 1'b1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(posedge clock); #1;
        while (!(idle === 1'b1 && le_idle === 1'b1) && guard < 1000) begin
            @(posedge clock); #1;
            guard++;
        end
        checks++;
        if (guard >= 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait_idle: idle=%b le_idle=%b pending=%0d", idle, le_idle, exp_q.size());
        end
    endtask

    task automatic wait_write_high();
        int guard = 0;
        while (m_write !== 1'b1 && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL wait_write: master_write=%b required 1", m_write);
        end
    endtask

    task automatic do_clear();
        clear_stats = 1'b1;
        @(posedge clock); #1;
        clear_stats = 1'b0;
        exp_pass = 0; exp_fail = 0; exp_le_pass = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({m_write, m_be, m_addr, m_data} !== 63'd0) begin
            errors++;
            $display("FAIL reset_bus: got %b/%h/%h/%h required all zero", m_write, m_be, m_addr, m_data);
        end
        checks++;
        if ({pass_cnt, fail_cnt} !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts: got %h/%h required 0/0", pass_cnt, fail_cnt);
        end
        checks++;
        if ({ovf, af, idle} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags: got ovf/af/idle=%b%b%b required 001", ovf, af, idle);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (idle !== 1'b1 || m_write !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got idle=%b write=%b required 1/0", idle, m_write);
        end
    endtask

    task automatic test_pass_basic();
        drive_frag(26'h000100, 32'h00000080, 32'h00000040, 24'hFF8800, 1'b1);
        checks++;
        if (m_write !== 1'b0) begin
            errors++; $display("FAIL latency_n: write=%b required 0", m_write);
        end
        @(posedge clock); #1;
        checks++;
        if (m_write !== 1'b0) begin
            errors++; $display("FAIL latency_n1: write=%b required 0", m_write);
        end
        @(posedge clock); #1;
        checks++;
        if (m_write !== 1'b1 || m_addr !== 26'h000100 || m_data !== 32'h00000040) begin
            errors++;
            $display("FAIL depth_write: got %b/%h/%h required 1/000100/00000040", m_write, m_addr, m_data);
        end
        @(posedge clock); #1;
        checks++;
        if (m_write !== 1'b1 || m_addr !== 26'h0200100 || m_data !== 32'h00FF8800) begin
            errors++;
            $display("FAIL color_write: got %b/%h/%h required 1/0200100/00ff8800", m_write, m_addr, m_data);
        end
        @(posedge clock); #1;
        checks++;
        if (m_write !== 1'b0 || idle !== 1'b0) begin
            errors++; $display("FAIL pop_cycle: write=%b idle=%b required 0/0", m_write, idle);
        end
        @(posedge clock); #1;
        checks++;
        if (idle !== 1'b1 || pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin
            errors++;
            $display("FAIL pass_done: idle=%b pass=%0d fail=%0d required 1/1/0", idle, pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_less_equal();
        int lw0;
        lw0 = le_writes;
        send(26'h000300, 32'h00000010, 32'h00000010, 24'h123456);
        wait_idle();
        checks++;
        if (fail_cnt !== 16'(exp_fail) || pass_cnt !== 16'(exp_pass)) begin
            errors++;
            $display("FAIL equal_strict: pass/fail=%0d/%0d required %0d/%0d", pass_cnt, fail_cnt, exp_pass, exp_fail);
        end
        checks++;
        if (le_writes - lw0 !== 2 || le_pass !== 4'(exp_le_pass)) begin
            errors++;
            $display("FAIL equal_inclusive: writes=%0d pass=%0d required 2/%0d", le_writes - lw0, le_pass, exp_le_pass);
        end
    endtask

    task automatic test_wait_hold();
        wait_mode = 1;
        drive_frag(26'h000400, 32'h00001000, 32'h00000800, 24'hABCDEF, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_write !== 1'b1 || m_addr !== 26'h000400 || m_data !== 32'h00000800) begin
                errors++;
                $display("FAIL wait_hold[%0d]: got %b/%h/%h required 1/000400/00000800", i, m_write, m_addr, m_data);
            end
            if (i < 3) begin
                @(posedge clock); #1;
            end
        end
        wait_mode = 0;
        @(posedge clock); #1;
        checks++;
        if (m_write !== 1'b1 || m_addr !== 26'h0200400 || m_data !== 32'h00ABCDEF) begin
            errors++;
            $display("FAIL wait_color: got %b/%h/%h required 1/0200400/00abcdef", m_write, m_addr, m_data);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive_frag(26'h000500 + 26'(i), 32'h00000001, 32'h00000100, 24'h000000, 1'b1);
        end
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (idle !== 1'b0) begin
            errors++; $display("FAIL fail_rate_early: idle=%b required 0", idle);
        end
        @(posedge clock); #1;
        checks++;
        if (idle !== 1'b1 || fail_cnt !== 16'(exp_fail)) begin
            errors++;
            $display("FAIL fail_rate: idle=%b fail=%0d required 1/%0d", idle, fail_cnt, exp_fail);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        wait_mode = 1;
        for (int i = 0; i < 6; i++) begin
            drive_frag(26'h001000 + 26'(i * 16), 32'hFFFF0000, 32'(i + 1), 24'(i), (i < 4));
            if (i == 1 || i == 2) begin
                checks++;
                if (af !== (i == 2)) begin
                    errors++;
                    $display("FAIL almost_full[%0d]: got %b required %b", i, af, (i == 2));
                end
            end
        end
        checks++;
        if (ovf !== 1'b1 || af !== 1'b1) begin
            errors++; $display("FAIL overflow_set: ovf=%b af=%b required 1/1", ovf, af);
        end
        wait_mode = 0;
        wait_idle();
        checks++;
        if (pass_cnt !== 16'd4 || ovf !== 1'b1) begin
            errors++; $display("FAIL overflow_drain: pass=%0d ovf=%b required 4/1", pass_cnt, ovf);
        end
        do_clear();
        checks++;
        if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clear_stats: pass=%0d fail=%0d ovf=%b required 0/0/0", pass_cnt, fail_cnt, ovf);
        end
    endtask

    task automatic test_pop_full();
        int guard = 0;
        wait_mode = 1;
        for (int i = 0; i < 4; i++) begin
            drive_frag(26'h002000 + 26'(i * 4), 32'h00000100, 32'(i), 24'(16 + i), 1'b1);
        end
        wait_write_high();
        wait_mode = 0;
        while (m_write !== 1'b0 && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        drive_frag(26'h002100, 32'h00000100, 32'h00000050, 24'h777777, 1'b1);
        checks++;
        if (ovf !== 1'b0 || af !== 1'b1 || guard >= 20) begin
            errors++;
            $display("FAIL pop_full: ovf=%b af=%b guard=%0d required 0/1/<20", ovf, af, guard);
        end
        wait_idle();
    endtask

    task automatic test_wrap_saturation();
        do_clear();
        send(26'h3FFFFF0, 32'h00000100, 32'h00000001, 24'h00FF00);
        wait_idle();
        checks++;
        if (last_wr_addr !== 26'h01FFFF0) begin
            errors++; $display("FAIL color_wrap: got %h required 01ffff0", last_wr_addr);
        end
        for (int i = 0; i < 17; i++) begin
            send(26'h003000 + 26'(i * 4), 32'h00008000, 32'($urandom_range(0, 32'h7FFF)), 24'($urandom));
        end
        wait_idle();
        checks++;
        if (pass_cnt !== 16'd18 || le_pass !== 4'hF) begin
            errors++;
            $display("FAIL saturation: pass=%0d le_pass=%h required 18/f", pass_cnt, le_pass);
        end
        do_clear();
        checks++;
        if (pass_cnt !== 16'd0 || le_pass !== 4'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clear_after_sat: pass=%0d le_pass=%0d ovf=%b required 0/0/0", pass_cnt, le_pass, ovf);
        end
    endtask

    task automatic test_random();
        logic [31:0] o, n;
        do_clear();
        wait_mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            o = $urandom;
            n = $urandom;
            if (n == o) n = o ^ 32'd1;
            send(26'($urandom), o, n, 24'($urandom));
        end
        wait_idle();
        wait_mode = 0;
        checks++;
        if (pass_cnt !== 16'(exp_pass) || fail_cnt !== 16'(exp_fail) || ovf !== 1'b0) begin
            errors++;
            $display("FAIL random_counts: pass/fail/ovf=%0d/%0d/%b required %0d/%0d/0",
                     pass_cnt, fail_cnt, ovf, exp_pass, exp_fail);
        end
        checks++;
        if (le_pass !== 4'(exp_le_pass)) begin
            errors++; $display("FAIL random_le_pass: got %0d required %0d", le_pass, exp_le_pass);
        end
    endtask

    task automatic test_reset_midwrite();
        wait_mode = 1;
        send(26'h002000, 32'h00000009, 32'h00000003, 24'h445566);
        wait_write_high();
        wait_mode = 0;
        @(posedge clock); #1;
        wait_mode = 1;
        checks++;
        if (m_write !== 1'b1 || m_addr !== 26'h0202000) begin
            errors++; $display("FAIL in_wr_color: got %b/%h required 1/0202000", m_write, m_addr);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (m_write !== 1'b0 || m_be !== 4'h0 || idle !== 1'b1 || af !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: write=%b be=%h idle=%b af=%b required 0/0/1/0", m_write, m_be, idle, af);
        end
        exp_q.delete();
        exp_pass = 0; exp_fail = 0; exp_le_pass = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        wait_mode = 0;
        @(posedge clock); #1;
        checks++;
        if (idle !== 1'b1 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
            errors++;
            $display("FAIL after_reset: idle=%b pass=%0d fail=%0d required 1/0/0", idle, pass_cnt, fail_cnt);
        end
        send(26'h000040, 32'h00000020, 32'h00000010, 24'h010203);
        wait_idle();
        checks++;
        if (pass_cnt !== 16'd1) begin
            errors++; $display("FAIL recover: pass=%0d required 1", pass_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_pass_basic();
        test_less_equal();
        test_wait_hold();
        test_back_to_back();
        test_overflow();
        test_pop_full();
        test_wrap_saturation();
        test_random();
        test_reset_midwrite();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
